// File: rtl/mlp_pkg.sv
// Shared neuron-datapath types: signed-magnitude word, lane count and the
// gather FSM encoding, plus negative-zero canonicalisation.
package mlp_pkg;
   localparam int N     = 16;
   localparam int F     = 8;
   localparam int LANES = 4;

   typedef logic [N-1:0] sm_word_t;

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} gather_state_t;

   // -0 (sign set, zero magnitude) becomes +0; every other word passes unchanged
   function automatic sm_word_t sm_canon(input sm_word_t w);
      return (w == {1'b1, {(N-1){1'b0}}}) ? '0 : w;
   endfunction
endpackage

// File: rtl/operand_gather4_if.sv
// Word stream in, 4-lane operand group out, plus the gather FSM state for observation.
// valid/ready: a beat transfers on a rising edge where valid && ready; a raised
// valid holds its payload stable until that edge.
interface operand_gather4_if;
   import mlp_pkg::*;

   logic          s_valid;
   logic          s_ready;
   sm_word_t      s_data;
   logic          s_last;
   logic          m_valid;
   logic          m_ready;
   sm_word_t      m_a0;
   sm_word_t      m_a1;
   sm_word_t      m_a2;
   sm_word_t      m_a3;
   logic [2:0]    m_count;
   logic          m_last;
   gather_state_t dbg_state;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_a0, m_a1, m_a2, m_a3, m_count, m_last, dbg_state
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_a0, m_a1, m_a2, m_a3, m_count, m_last, dbg_state
   );
endinterface

// File: rtl/operand_gather4.sv
// Packs a serial signed-magnitude word stream into zero-padded 4-lane groups
// for one adder-tree reduction each, with a collect stage and an output register.
module operand_gather4
   import mlp_pkg::*;
(
   input logic              clk,
   input logic              rst_n,
   operand_gather4_if.slave bus
);

   gather_state_t state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   sm_word_t      c_q [0:LANES-1];
   sm_word_t      c_d [0:LANES-1];
   logic [2:0]    hcount_q, hcount_d;
   logic          hlast_q, hlast_d;
   logic          mv_q, mv_d;
   sm_word_t      ma_q [0:LANES-1];
   sm_word_t      ma_d [0:LANES-1];
   logic [2:0]    mcount_q, mcount_d;
   logic          mlast_q, mlast_d;

   sm_word_t      grp [0:LANES-1];
   logic [2:0]    grp_cnt;
   logic          grp_last;
   logic          load_out;
   logic          out_free;
   logic          complete;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      c_d      = c_q;
      hcount_d = hcount_q;
      hlast_d  = hlast_q;
      mv_d     = mv_q;
      ma_d     = ma_q;
      mcount_d = mcount_q;
      mlast_d  = mlast_q;
      grp      = c_q;
      grp_cnt  = hcount_q;
      grp_last = hlast_q;
      load_out = 1'b0;
      complete = 1'b0;
      out_free = !mv_q || bus.m_ready;

      if (mv_q && bus.m_ready) mv_d = 1'b0;

      case (state_q)
         COLLECT: begin
            if (bus.s_valid) begin
               // Lanes past the write index are padding and read as +0
               for (int j = 0; j < LANES; j++) begin
                  if (2'(j) == idx_q)     grp[j] = sm_canon(bus.s_data);
                  else if (2'(j) > idx_q) grp[j] = '0;
               end
               complete = (idx_q == 2'd3) || bus.s_last;
               if (complete) begin
                  c_d      = grp;
                  idx_d    = 2'd0;
                  grp_cnt  = 3'(idx_q) + 3'd1;
                  grp_last = bus.s_last;
                  hcount_d = grp_cnt;
                  hlast_d  = grp_last;
                  if (out_free) load_out = 1'b1;
                  else          state_d  = HOLD;
               end else begin
                  c_d[idx_q] = sm_canon(bus.s_data);
                  idx_d      = idx_q + 2'd1;
               end
            end
         end
         HOLD: begin
            if (out_free) begin
               load_out = 1'b1;
               state_d  = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase

      if (load_out) begin
         mv_d     = 1'b1;
         ma_d     = grp;
         mcount_d = grp_cnt;
         mlast_d  = grp_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= COLLECT;
         idx_q    <= '0;
         c_q      <= '{default: '0};
         hcount_q <= '0;
         hlast_q  <= 1'b0;
         mv_q     <= 1'b0;
         ma_q     <= '{default: '0};
         mcount_q <= '0;
         mlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         c_q      <= c_d;
         hcount_q <= hcount_d;
         hlast_q  <= hlast_d;
         mv_q     <= mv_d;
         ma_q     <= ma_d;
         mcount_q <= mcount_d;
         mlast_q  <= mlast_d;
      end
   end

   // Ready depends only on registered state, so it never follows s_valid or m_ready
   assign bus.s_ready   = (state_q == COLLECT);
   assign bus.m_valid   = mv_q;
   assign bus.m_a0      = ma_q[0];
   assign bus.m_a1      = ma_q[1];
   assign bus.m_a2      = ma_q[2];
   assign bus.m_a3      = ma_q[3];
   assign bus.m_count   = mcount_q;
   assign bus.m_last    = mlast_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_operand_gather4.sv
// Directed and throttled-random bench for operand_gather4: every delivered group
// is compared against hand-written or modelled expectations.
module tb_operand_gather4;
   import mlp_pkg::*;

   localparam int GW = 4*N + 4;

   logic clk;
   logic rst_n;
   logic rand_mode;
   int   n_checks;
   int   n_err;

   logic [GW-1:0] exp_q[$];
   logic [GW-1:0] got_q[$];

   sm_word_t   model_lanes [0:3];
   int         model_idx;

   logic          stall_prev;
   logic [GW-1:0] snap;

   operand_gather4_if bus();

   operand_gather4 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [GW-1:0] pack(input sm_word_t a0, input sm_word_t a1,
                                          input sm_word_t a2, input sm_word_t a3,
                                          input logic [2:0] cnt, input logic last);
      return {a0, a1, a2, a3, cnt, last};
   endfunction

   function automatic logic [GW-1:0] out_now();
      return pack(bus.m_a0, bus.m_a1, bus.m_a2, bus.m_a3, bus.m_count, bus.m_last);
   endfunction

   task automatic check(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Independent reference for the random phase
   task automatic model_push(input sm_word_t d, input logic l);
      sm_word_t w;
      w = (d == 16'h8000) ? 16'h0000 : d;
      model_lanes[model_idx] = w;
      if (model_idx == 3 || l) begin
         for (int j = 0; j < 4; j++) if (j > model_idx) model_lanes[j] = '0;
         exp_q.push_back(pack(model_lanes[0], model_lanes[1], model_lanes[2], model_lanes[3],
                              3'(model_idx + 1), l));
         model_idx = 0;
      end else begin
         model_idx++;
      end
   endtask

   // ---------------- driver ----------------
   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input sm_word_t d, input logic l, output int waits);
      int n;
      n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      forever begin
         @(negedge clk);
         if (bus.s_ready) break;
         n++;
         if (n > 300) begin
            n_checks++;
            n_err++;
            $error("FAIL send_timeout observed=s_ready_low expected=accept");
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      waits = n;
   endtask

   task automatic check_groups(input string tag);
      int n;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 5000) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_groups"}, GW'(got_q.size()), GW'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0)
         check(tag, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst_n && bus.m_valid && bus.m_ready) got_q.push_back(out_now());
      if (rst_n && stall_prev) check("stall_stable", out_now(), snap);
      stall_prev = rst_n && bus.m_valid && !bus.m_ready;
      snap       = out_now();
   end

   always @(negedge rst_n) stall_prev = 1'b0;

   always @(posedge clk) begin
      #1;
      if (rand_mode) bus.m_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int w;
      int idle;
      sm_word_t d;
      logic l;
      n_checks    = 0;
      n_err       = 0;
      rand_mode   = 1'b0;
      stall_prev  = 1'b0;
      model_idx   = 0;
      model_lanes = '{default: '0};
      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      check("reset_m_valid", GW'(bus.m_valid), GW'(0));
      check("reset_outputs", out_now(), '0);
      check("reset_s_ready", GW'(bus.s_ready), GW'(1));

      // Two full groups at full rate
      bus.m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         send(sm_word_t'(i), (i == 8), w);
         check("t1_no_wait", GW'(w), GW'(0));
         if (i == 4) begin
            check("t1_latency_valid", GW'(bus.m_valid), GW'(1));
            check("t1_first_out", out_now(), pack(16'h1, 16'h2, 16'h3, 16'h4, 3'd4, 1'b0));
         end
      end
      check("t1_latency_valid2", GW'(bus.m_valid), GW'(1));
      exp_q.push_back(pack(16'h1, 16'h2, 16'h3, 16'h4, 3'd4, 1'b0));
      exp_q.push_back(pack(16'h5, 16'h6, 16'h7, 16'h8, 3'd4, 1'b1));
      check_groups("t1");

      // Short final group and single-word neuron
      for (int i = 0; i < 6; i++) send(sm_word_t'(16'h00A + i), (i == 5), w);
      send(16'h0123, 1'b1, w);
      exp_q.push_back(pack(16'h00A, 16'h00B, 16'h00C, 16'h00D, 3'd4, 1'b0));
      exp_q.push_back(pack(16'h00E, 16'h00F, 16'h000, 16'h000, 3'd2, 1'b1));
      exp_q.push_back(pack(16'h123, 16'h000, 16'h000, 16'h000, 3'd1, 1'b1));
      check_groups("t2");

      // Negative zero canonicalised, -1 LSB untouched
      send(16'h0005, 1'b0, w);
      send(16'h0006, 1'b0, w);
      send(16'h8000, 1'b0, w);
      send(16'h8001, 1'b1, w);
      exp_q.push_back(pack(16'h0005, 16'h0006, 16'h0000, 16'h8001, 3'd4, 1'b1));
      check_groups("t3_negzero");

      // Backpressure: one group in output, one held, collector blocked
      bus.m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(sm_word_t'(16'h100 + i), 1'b0, w);
      check("t4_s_ready_low", GW'(bus.s_ready), GW'(0));
      check("t4_state_hold", GW'(bus.dbg_state), GW'(HOLD));
      check("t4_out_first", out_now(), pack(16'h101, 16'h102, 16'h103, 16'h104, 3'd4, 1'b0));
      repeat (3) @(posedge clk);
      #1;
      check("t4_still_blocked", GW'(bus.s_ready), GW'(0));
      bus.m_ready = 1'b1;
      for (int i = 9; i <= 12; i++) send(sm_word_t'(16'h100 + i), (i == 12), w);
      exp_q.push_back(pack(16'h101, 16'h102, 16'h103, 16'h104, 3'd4, 1'b0));
      exp_q.push_back(pack(16'h105, 16'h106, 16'h107, 16'h108, 3'd4, 1'b0));
      exp_q.push_back(pack(16'h109, 16'h10A, 16'h10B, 16'h10C, 3'd4, 1'b1));
      check_groups("t4");

      // Reset mid-group discards the partial group
      send(16'h0011, 1'b0, w);
      send(16'h0012, 1'b0, w);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_outputs", out_now(), '0);
      check("t5_rst_valid", GW'(bus.m_valid), GW'(0));
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("t5_s_ready", GW'(bus.s_ready), GW'(1));
      for (int i = 1; i <= 4; i++) send(sm_word_t'(16'h20 + i), 1'b0, w);
      exp_q.push_back(pack(16'h21, 16'h22, 16'h23, 16'h24, 3'd4, 1'b0));
      check_groups("t5");

      // Reset while a group is held
      bus.m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(sm_word_t'(16'h40 + i), 1'b0, w);
      check("t6_state_hold", GW'(bus.dbg_state), GW'(HOLD));
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_outputs", out_now(), '0);
      check("t6_rst_valid", GW'(bus.m_valid), GW'(0));
      check("t6_rst_state", GW'(bus.dbg_state), GW'(COLLECT));
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("t6_s_ready", GW'(bus.s_ready), GW'(1));
      bus.m_ready = 1'b1;
      for (int i = 1; i <= 4; i++) send(sm_word_t'(16'h30 + i), (i == 4), w);
      exp_q.push_back(pack(16'h31, 16'h32, 16'h33, 16'h34, 3'd4, 1'b1));
      check_groups("t6");

      // Random valid/ready throttling against the reference model
      model_idx = 0;
      rand_mode = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         idle = $urandom_range(0, 2);
         repeat (idle) begin
            @(posedge clk);
            #1;
         end
         d = ($urandom_range(0, 15) == 0) ? 16'h8000 : sm_word_t'($urandom_range(0, 16'hFFFF));
         l = ($urandom_range(0, 6) == 0) || (i == 1499);
         model_push(d, l);
         send(d, l, w);
      end
      rand_mode   = 1'b0;
      bus.m_ready = 1'b1;
      check_groups("t7_random");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
